hash_result_scanner: RTL and testbench

- Post-processing reader for the nonce-sweep hash engine, which writes one H0 word per nonce into a contiguous result region of shared memory.
- Once the engine reports done, this block reads that region back. It finds the smallest H0 and its nonce, and counts the words strictly below a difficulty target.
- It writes a two-word summary back to memory and presents the same results on ports.
- It shares the single-port synchronous memory interface style used by the hash engine.

---
 rtl/hash_result_scanner.sv | 147 ++++++++++++++
 tb/tb_hash_result_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hash_result_scanner.sv
// rtl/hash_result_scanner.sv - scans nonce-sweep H0 results for the minimum and target hits, writes a 2-word summary
// Latency: start sampled at edge 0 gives done high after edge NUM_NONCES+4; summary lands at summary_addr, summary_addr+1.
module hash_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] result_addr,
  input  logic [15:0] summary_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic [7:0]  hit_count,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    SCAN   = 3'd2,
    WR_MIN = 3'd3,
    WR_SUM = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

  state_t      state, state_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [15:0] summary_q, summary_nxt;
  logic [31:0] target_q, target_nxt;
  logic        done_nxt, found_nxt, mem_we_nxt;
  logic [7:0]  best_nonce_nxt, hit_count_nxt;
  logic [31:0] best_hash_nxt, mem_write_data_nxt;
  logic [15:0] mem_addr_nxt;

  assign mem_clk = clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= 8'd0;
      summary_q      <= 16'd0;
      target_q       <= 32'd0;
      done           <= 1'b0;
      found          <= 1'b0;
      best_nonce     <= 8'd0;
      best_hash      <= 32'd0;
      hit_count      <= 8'd0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'd0;
      mem_write_data <= 32'd0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      summary_q      <= summary_nxt;
      target_q       <= target_nxt;
      done           <= done_nxt;
      found          <= found_nxt;
      best_nonce     <= best_nonce_nxt;
      best_hash      <= best_hash_nxt;
      hit_count      <= hit_count_nxt;
      mem_we         <= mem_we_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_write_data <= mem_write_data_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    idx_nxt            = idx;
    summary_nxt        = summary_q;
    target_nxt         = target_q;
    done_nxt           = 1'b0;
    found_nxt          = found;
    best_nonce_nxt     = best_nonce;
    best_hash_nxt      = best_hash;
    hit_count_nxt      = hit_count;
    mem_we_nxt         = 1'b0;
    mem_addr_nxt       = mem_addr;
    mem_write_data_nxt = mem_write_data;

    case (state)
      IDLE: begin
        if (start) begin
          summary_nxt    = summary_addr;
          target_nxt     = target;
          mem_addr_nxt   = result_addr;
          hit_count_nxt  = 8'd0;
          found_nxt      = 1'b0;
          best_nonce_nxt = 8'd0;
          best_hash_nxt  = 32'd0;
          idx_nxt        = 8'd0;
          state_nxt      = PRIME;
        end
      end
      PRIME: begin
        mem_addr_nxt = mem_addr + 16'd1;
        state_nxt    = SCAN;
      end
      SCAN: begin
        // Word 0 seeds the minimum; strict compare keeps the lowest nonce on ties.
        if (idx == 8'd0 || mem_read_data < best_hash) begin
          best_hash_nxt  = mem_read_data;
          best_nonce_nxt = idx;
        end
        if (mem_read_data < target_q) begin
          hit_count_nxt = hit_count + 8'd1;
        end
        mem_addr_nxt = mem_addr + 16'd1;
        if (idx == LAST_IDX) begin
          state_nxt = WR_MIN;
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      WR_MIN: begin
        mem_we_nxt         = 1'b1;
        mem_addr_nxt       = summary_q;
        mem_write_data_nxt = best_hash;
        state_nxt          = WR_SUM;
      end
      WR_SUM: begin
        mem_we_nxt         = 1'b1;
        mem_addr_nxt       = summary_q + 16'd1;
        mem_write_data_nxt = {(hit_count != 8'd0), 15'b0, hit_count, best_nonce};
        state_nxt          = FIN;
      end
      FIN: begin
        done_nxt  = 1'b1;
        found_nxt = (hit_count != 8'd0);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hash_result_scanner.sv
// tb/tb_hash_result_scanner.sv - directed-vector bench for hash_result_scanner (16-nonce and 1-nonce instances)
module tb_hash_result_scanner;

  logic        clk;
  logic        reset_n;

  logic        a_start, a_done, a_found, a_we, a_mclk;
  logic [15:0] a_ra, a_sa, a_addr;
  logic [31:0] a_tgt, a_hash, a_wdata, a_rd;
  logic [7:0]  a_nonce, a_hits;

  logic        b_start, b_done, b_found, b_we, b_mclk;
  logic [15:0] b_ra, b_sa, b_addr;
  logic [31:0] b_tgt, b_hash, b_wdata, b_rd;
  logic [7:0]  b_nonce, b_hits;

  logic [31:0] mem_a [0:65535];
  logic [31:0] mem_b [0:65535];
  int          wr_cnt_a, wr_cnt_b, done_cnt_a;

  int vectors, miscompares;

  hash_result_scanner #(.NUM_NONCES(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .result_addr(a_ra), .summary_addr(a_sa),
    .target(a_tgt), .done(a_done), .found(a_found), .best_nonce(a_nonce), .best_hash(a_hash),
    .hit_count(a_hits), .mem_clk(a_mclk), .mem_we(a_we), .mem_addr(a_addr),
    .mem_write_data(a_wdata), .mem_read_data(a_rd)
  );

  hash_result_scanner #(.NUM_NONCES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .result_addr(b_ra), .summary_addr(b_sa),
    .target(b_tgt), .done(b_done), .found(b_found), .best_nonce(b_nonce), .best_hash(b_hash),
    .hit_count(b_hits), .mem_clk(b_mclk), .mem_we(b_we), .mem_addr(b_addr),
    .mem_write_data(b_wdata), .mem_read_data(b_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge a_mclk) begin
    if (a_we) begin
      mem_a[a_addr] = a_wdata;
      wr_cnt_a = wr_cnt_a + 1;
    end
    a_rd <= mem_a[a_addr];
  end

  always @(posedge b_mclk) begin
    if (b_we) begin
      mem_b[b_addr] = b_wdata;
      wr_cnt_b = wr_cnt_b + 1;
    end
    b_rd <= mem_b[b_addr];
  end

  always @(negedge clk) begin
    if (a_done) done_cnt_a = done_cnt_a + 1;
  end

  task automatic load_descending();
    for (int i = 0; i < 16; i++) mem_a[100 + i] = 32'h9000_0000 - 32'h0100_0000 * i;
    mem_a[200] = 32'hDEAD_BEEF;
    mem_a[201] = 32'hDEAD_BEEF;
  endtask

  task automatic run_a(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tg,
                       output int cyc);
    @(negedge clk);
    a_ra = ra; a_sa = sa; a_tgt = tg; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wr_cnt_a = 0;
    cyc = 0;
    while (cyc < 60 && !a_done) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", a_done); end
    vectors++; if (a_found !== 1'b0) begin miscompares++; $display("FAIL reset_found got %0b want 0", a_found); end
    vectors++; if (a_nonce !== 8'd0) begin miscompares++; $display("FAIL reset_nonce got %0d want 0", a_nonce); end
    vectors++; if (a_hash !== 32'd0) begin miscompares++; $display("FAIL reset_hash got %h want 0", a_hash); end
    vectors++; if (a_hits !== 8'd0) begin miscompares++; $display("FAIL reset_hits got %0d want 0", a_hits); end
    vectors++; if (a_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %0b want 0", a_we); end
    vectors++; if (a_addr !== 16'd0) begin miscompares++; $display("FAIL reset_addr got %h want 0", a_addr); end
    vectors++; if (a_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", a_wdata); end
  endtask

  task automatic test_descending();
    int cyc;
    load_descending();
    run_a(16'd100, 16'd200, 32'h8800_0000, cyc);
    vectors++; if (cyc !== 20) begin miscompares++; $display("FAIL desc_latency got %0d want 20", cyc); end
    vectors++; if (a_hash !== 32'h8100_0000) begin miscompares++; $display("FAIL desc_hash got %h want 81000000", a_hash); end
    vectors++; if (a_nonce !== 8'd15) begin miscompares++; $display("FAIL desc_nonce got %0d want 15", a_nonce); end
    vectors++; if (a_hits !== 8'd7) begin miscompares++; $display("FAIL desc_hits got %0d want 7", a_hits); end
    vectors++; if (a_found !== 1'b1) begin miscompares++; $display("FAIL desc_found got %0b want 1", a_found); end
    vectors++; if (mem_a[200] !== 32'h8100_0000) begin miscompares++; $display("FAIL desc_mem200 got %h want 81000000", mem_a[200]); end
    vectors++; if (mem_a[201] !== 32'h8000_070F) begin miscompares++; $display("FAIL desc_mem201 got %h want 8000070f", mem_a[201]); end
    vectors++; if (wr_cnt_a !== 2) begin miscompares++; $display("FAIL desc_writes got %0d want 2", wr_cnt_a); end
    @(negedge clk);
    vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL desc_done_width got %0b want 0", a_done); end
    vectors++; if (a_nonce !== 8'd15 || a_hits !== 8'd7) begin miscompares++; $display("FAIL desc_hold got %0d/%0d want 15/7", a_nonce, a_hits); end
  endtask

  task automatic test_tie();
    int cyc;
    for (int i = 0; i < 16; i++) mem_a[100 + i] = 32'hFFFF_FFF0;
    mem_a[105] = 32'h0000_0010;
    mem_a[109] = 32'h0000_0010;
    run_a(16'd100, 16'd200, 32'h0000_0010, cyc);
    vectors++; if (cyc !== 20) begin miscompares++; $display("FAIL tie_latency got %0d want 20", cyc); end
    vectors++; if (a_nonce !== 8'd5) begin miscompares++; $display("FAIL tie_nonce got %0d want 5", a_nonce); end
    vectors++; if (a_hash !== 32'h10) begin miscompares++; $display("FAIL tie_hash got %h want 10", a_hash); end
    vectors++; if (a_hits !== 8'd0) begin miscompares++; $display("FAIL tie_hits got %0d want 0", a_hits); end
    vectors++; if (a_found !== 1'b0) begin miscompares++; $display("FAIL tie_found got %0b want 0", a_found); end
    vectors++; if (mem_a[201] !== 32'h0000_0005) begin miscompares++; $display("FAIL tie_mem201 got %h want 00000005", mem_a[201]); end
  endtask

  task automatic test_all_hit();
    int cyc;
    for (int i = 0; i < 16; i++) mem_a[100 + i] = 32'h0000_1234;
    run_a(16'd100, 16'd200, 32'hFFFF_FFFF, cyc);
    vectors++; if (a_nonce !== 8'd0) begin miscompares++; $display("FAIL all_nonce got %0d want 0", a_nonce); end
    vectors++; if (a_hits !== 8'd16) begin miscompares++; $display("FAIL all_hits got %0d want 16", a_hits); end
    vectors++; if (a_found !== 1'b1) begin miscompares++; $display("FAIL all_found got %0b want 1", a_found); end
    vectors++; if (mem_a[201] !== 32'h8000_1000) begin miscompares++; $display("FAIL all_mem201 got %h want 80001000", mem_a[201]); end
  endtask

  task automatic test_target_zero();
    int cyc;
    load_descending();
    run_a(16'd100, 16'd200, 32'h0000_0000, cyc);
    vectors++; if (a_hits !== 8'd0 || a_found !== 1'b0) begin miscompares++; $display("FAIL tz_hits got %0d/%0b want 0/0", a_hits, a_found); end
    vectors++; if (mem_a[201] !== 32'h0000_000F) begin miscompares++; $display("FAIL tz_mem201 got %h want 0000000f", mem_a[201]); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    load_descending();
    @(negedge clk);
    a_ra = 16'd100; a_sa = 16'd200; a_tgt = 32'h8800_0000; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wr_cnt_a = 0;
    done_cnt_a = 0;
    repeat (7) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    vectors++; if ({a_done, a_found, a_we} !== 3'b000) begin miscompares++; $display("FAIL rst_async_flags got %b want 000", {a_done, a_found, a_we}); end
    vectors++; if (a_hash !== 32'd0 || a_nonce !== 8'd0 || a_hits !== 8'd0) begin miscompares++; $display("FAIL rst_async_results got %h/%0d/%0d want 0/0/0", a_hash, a_nonce, a_hits); end
    vectors++; if (a_addr !== 16'd0 || a_wdata !== 32'd0) begin miscompares++; $display("FAIL rst_async_mem got %h/%h want 0/0", a_addr, a_wdata); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    vectors++; if (wr_cnt_a !== 0 || done_cnt_a !== 0) begin miscompares++; $display("FAIL rst_no_writes got %0d writes %0d dones want 0/0", wr_cnt_a, done_cnt_a); end
    vectors++; if (mem_a[201] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rst_mem201 got %h want deadbeef", mem_a[201]); end
    run_a(16'd100, 16'd200, 32'h8800_0000, cyc);
    vectors++; if (cyc !== 20) begin miscompares++; $display("FAIL rst_rerun_latency got %0d want 20", cyc); end
    vectors++; if (mem_a[201] !== 32'h8000_070F) begin miscompares++; $display("FAIL rst_rerun_mem201 got %h want 8000070f", mem_a[201]); end
  endtask

  task automatic test_start_ignored();
    int first_done;
    load_descending();
    mem_a[210] = 32'hCAFE_0000;
    mem_a[211] = 32'hCAFE_0001;
    first_done = -1;
    @(negedge clk);
    a_ra = 16'd100; a_sa = 16'd200; a_tgt = 32'h8800_0000; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_ra = 16'd0; a_sa = 16'd210; a_tgt = 32'h0;
    wr_cnt_a = 0;
    done_cnt_a = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (a_done && first_done < 0) first_done = c;
      a_start = (c == 5 || c == 17);
    end
    a_start = 1'b0;
    vectors++; if (done_cnt_a !== 1) begin miscompares++; $display("FAIL ign_done_count got %0d want 1", done_cnt_a); end
    vectors++; if (first_done !== 20) begin miscompares++; $display("FAIL ign_done_cycle got %0d want 20", first_done); end
    vectors++; if (a_hits !== 8'd7 || a_nonce !== 8'd15) begin miscompares++; $display("FAIL ign_results got %0d/%0d want 7/15", a_hits, a_nonce); end
    vectors++; if (wr_cnt_a !== 2 || mem_a[210] !== 32'hCAFE_0000) begin miscompares++; $display("FAIL ign_writes got %0d/%h want 2/cafe0000", wr_cnt_a, mem_a[210]); end
  endtask

  task automatic test_single();
    int cyc;
    mem_b[50] = 32'h0000_0001;
    mem_b[60] = 32'hDEAD_BEEF;
    mem_b[61] = 32'hDEAD_BEEF;
    @(negedge clk);
    b_ra = 16'd50; b_sa = 16'd60; b_tgt = 32'h0000_0002; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wr_cnt_b = 0;
    cyc = 0;
    while (cyc < 30 && !b_done) begin
      @(negedge clk);
      cyc++;
    end
    vectors++; if (cyc !== 5) begin miscompares++; $display("FAIL one_latency got %0d want 5", cyc); end
    vectors++; if (b_nonce !== 8'd0 || b_hash !== 32'h1) begin miscompares++; $display("FAIL one_best got %0d/%h want 0/1", b_nonce, b_hash); end
    vectors++; if (b_hits !== 8'd1 || b_found !== 1'b1) begin miscompares++; $display("FAIL one_hits got %0d/%0b want 1/1", b_hits, b_found); end
    vectors++; if (mem_b[61] !== 32'h8000_0100) begin miscompares++; $display("FAIL one_mem61 got %h want 80000100", mem_b[61]); end
    vectors++; if (mem_b[60] !== 32'h0000_0001) begin miscompares++; $display("FAIL one_mem60 got %h want 00000001", mem_b[60]); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    wr_cnt_a = 0; wr_cnt_b = 0; done_cnt_a = 0;
    a_start = 1'b0; a_ra = 16'd0; a_sa = 16'd0; a_tgt = 32'd0;
    b_start = 1'b0; b_ra = 16'd0; b_sa = 16'd0; b_tgt = 32'd0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_descending();
    test_tie();
    test_all_hit();
    test_target_zero();
    test_reset_mid_scan();
    test_start_ignored();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
